// File: rtl/alu_issue_if.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : alu_issue_if
// Purpose  : Bundles the instruction handshake, the external ALU operand /
//            result path, the write-back strobe, the illegal-instruction
//            pulse and the debug register-file read port of alu_issue.
// Ports    : instr_valid/instr_ready/instr   instruction handshake
//            alu_opcode/alu_left/alu_right   operands to combinational ALU
//            alu_result                      ALU result back into the block
//            rd_valid/rd_addr/rd_data        write-back strobe
//            illegal                         undecodable-instruction pulse
//            dbg_raddr/dbg_rdata             debug register-file read
// Modports : slave  - the issue block itself
//            master - the environment (fetch side, ALU, debug host)
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
interface alu_issue_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [2:0]  alu_opcode;
   logic [31:0] alu_left;
   logic [31:0] alu_right;
   logic [31:0] alu_result;
   logic        rd_valid;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        illegal;
   logic [4:0]  dbg_raddr;
   logic [31:0] dbg_rdata;

   modport slave (
      input  instr_valid, instr, alu_result, dbg_raddr,
      output instr_ready, alu_opcode, alu_left, alu_right,
             rd_valid, rd_addr, rd_data, illegal, dbg_rdata
   );

   modport master (
      output instr_valid, instr, alu_result, dbg_raddr,
      input  instr_ready, alu_opcode, alu_left, alu_right,
             rd_valid, rd_addr, rd_data, illegal, dbg_rdata
   );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : alu_issue
// Purpose  : Three-cycle issue/execute/write-back sequencer for a tiny RV32
//            subset (ADD, SUB, AND, ADDI, ANDI). Decodes an accepted word,
//            reads operands from an internal 32x32 register file, drives an
//            external combinational ALU, captures its result and writes it
//            back. Undecodable words raise a one-cycle illegal pulse.
// Ports    : clk    - sole clock, rising edge
//            rst_n  - synchronous active-low reset
//            io_bus - alu_issue_if.slave (handshake, ALU, write-back, debug)
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
module alu_issue (
   input  logic           clk,
   input  logic           rst_n,
   alu_issue_if.slave     io_bus
);

   // ALU operation encoding shared with the external ALU
   localparam logic [2:0] c_ALU_OP_ADD = 3'd0;
   localparam logic [2:0] c_ALU_OP_SUB = 3'd1;
   localparam logic [2:0] c_ALU_OP_AND = 3'd2;

   localparam logic [6:0] c_OPC_OP     = 7'b0110011;
   localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] c_F7_BASE    = 7'b0000000;
   localparam logic [6:0] c_F7_ALT     = 7'b0100000;
   localparam logic [2:0] c_F3_ADD     = 3'b000;
   localparam logic [2:0] c_F3_AND     = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_regs [0:31];
   logic [2:0]  r_op;
   logic [31:0] r_left;
   logic [31:0] r_right;
   logic [4:0]  r_rd;
   logic [31:0] r_result;
   logic        r_illegal;

   logic        w_ready;
   logic        w_rd_valid;
   logic        w_accept;

   // Instruction field extraction
   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [4:0]  w_rd;
   logic [31:0] w_imm;
   logic [31:0] w_rs1_val;
   logic [31:0] w_rs2_val;

   logic        w_legal;
   logic [2:0]  w_dec_op;
   logic        w_use_imm;

   assign w_opcode = io_bus.instr[6:0];
   assign w_rd     = io_bus.instr[11:7];
   assign w_funct3 = io_bus.instr[14:12];
   assign w_rs1    = io_bus.instr[19:15];
   assign w_rs2    = io_bus.instr[24:20];
   assign w_funct7 = io_bus.instr[31:25];
   assign w_imm    = {{20{io_bus.instr[31]}}, io_bus.instr[31:20]};

   // x0 is hard-wired to zero on every read port, independent of storage
   assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
   assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

   //-------------------------------------------------------------------------
   // Decoder: anything not explicitly matched is illegal
   //-------------------------------------------------------------------------
   always_comb begin
      w_legal   = 1'b0;
      w_dec_op  = c_ALU_OP_ADD;
      w_use_imm = 1'b0;
      case (w_opcode)
         c_OPC_OP: begin
            if (w_funct7 == c_F7_BASE && w_funct3 == c_F3_ADD) begin
               w_legal  = 1'b1;
               w_dec_op = c_ALU_OP_ADD;
            end else if (w_funct7 == c_F7_ALT && w_funct3 == c_F3_ADD) begin
               w_legal  = 1'b1;
               w_dec_op = c_ALU_OP_SUB;
            end else if (w_funct7 == c_F7_BASE && w_funct3 == c_F3_AND) begin
               w_legal  = 1'b1;
               w_dec_op = c_ALU_OP_AND;
            end
         end
         c_OPC_OPIMM: begin
            if (w_funct3 == c_F3_ADD) begin
               w_legal   = 1'b1;
               w_dec_op  = c_ALU_OP_ADD;
               w_use_imm = 1'b1;
            end else if (w_funct3 == c_F3_AND) begin
               w_legal   = 1'b1;
               w_dec_op  = c_ALU_OP_AND;
               w_use_imm = 1'b1;
            end
         end
         default: ;
      endcase
   end

   //-------------------------------------------------------------------------
   // FSM: state register
   //-------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //-------------------------------------------------------------------------
   // FSM: next state and control outputs. Ready and the write-back strobe
   // are masked by rst_n so that nothing is offered or retired while reset
   // is held, even before the first reset edge has cleared the state.
   //-------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_rd_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = rst_n;
            // Illegal words are consumed in place: the FSM stays in IDLE
            if (w_accept && w_legal) begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            w_state_nxt = S_WB;
         end
         S_WB: begin
            w_rd_valid  = rst_n;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_accept = io_bus.instr_valid && w_ready;

   //-------------------------------------------------------------------------
   // Datapath: operand latch, result capture, register-file write
   //-------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op      <= 3'd0;
         r_left    <= 32'd0;
         r_right   <= 32'd0;
         r_rd      <= 5'd0;
         r_result  <= 32'd0;
         r_illegal <= 1'b0;
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= 32'd0;
         end
      end else begin
         r_illegal <= w_accept && !w_legal;

         // Operands are read at accept time; the previous write-back has
         // always retired by then, so no forwarding path is needed.
         if (w_accept && w_legal) begin
            r_op    <= w_dec_op;
            r_left  <= w_rs1_val;
            r_right <= w_use_imm ? w_imm : w_rs2_val;
            r_rd    <= w_rd;
         end

         if (r_state == S_EXEC) begin
            r_result <= io_bus.alu_result;
         end

         if (r_state == S_WB && r_rd != 5'd0) begin
            r_regs[r_rd] <= r_result;
         end
      end
   end

   //-------------------------------------------------------------------------
   // Outputs. The ALU operands come straight from the latch: they only move
   // on an accept, so they are stable through EXEC and hold afterwards.
   //-------------------------------------------------------------------------
   assign io_bus.instr_ready = w_ready;
   assign io_bus.alu_opcode  = r_op;
   assign io_bus.alu_left    = r_left;
   assign io_bus.alu_right   = r_right;
   assign io_bus.rd_valid    = w_rd_valid;
   assign io_bus.rd_addr     = r_rd;
   assign io_bus.rd_data     = r_result;
   assign io_bus.illegal     = r_illegal;
   assign io_bus.dbg_rdata   = (io_bus.dbg_raddr == 5'd0) ? 32'd0
                                                          : r_regs[io_bus.dbg_raddr];

endmodule
`default_nettype wire
